// File: rtl/ddr_arbiter_if.sv
// Requester and DDR-controller signal bundle for ddr_arbiter.
// The arbiter takes the slave modport; the environment drives through master.
interface ddr_arbiter_if #(
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned DATA_W = 128
);
  logic              init_done;
  logic              cmd_busy;

  logic              cam_wr_req;
  logic [ADDR_W-1:0] cam_wr_addr;
  logic [DATA_W-1:0] cam_wr_data;
  logic              cam_wr_ack;

  logic              vga_rd_req;
  logic [ADDR_W-1:0] vga_rd_addr;
  logic              vga_rd_ack;
  logic              vga_rd_valid;

  logic              hdr_rd_req;
  logic [ADDR_W-1:0] hdr_rd_addr;
  logic              hdr_rd_ack;
  logic              hdr_rd_valid;

  logic [3:0]        cmd;
  logic              cmd_valid;
  logic [ADDR_W-1:0] ddr_address;
  logic [DATA_W-1:0] ddr_wr_data;

  logic              ddr_data_valid;
  logic [DATA_W-1:0] ddr_rd_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_underflow;

  modport master (
    output init_done, cmd_busy,
    output cam_wr_req, cam_wr_addr, cam_wr_data,
    input  cam_wr_ack,
    output vga_rd_req, vga_rd_addr,
    input  vga_rd_ack, vga_rd_valid,
    output hdr_rd_req, hdr_rd_addr,
    input  hdr_rd_ack, hdr_rd_valid,
    input  cmd, cmd_valid, ddr_address, ddr_wr_data,
    output ddr_data_valid, ddr_rd_data,
    input  rd_data, rd_underflow
  );

  modport slave (
    input  init_done, cmd_busy,
    input  cam_wr_req, cam_wr_addr, cam_wr_data,
    output cam_wr_ack,
    input  vga_rd_req, vga_rd_addr,
    output vga_rd_ack, vga_rd_valid,
    input  hdr_rd_req, hdr_rd_addr,
    output hdr_rd_ack, hdr_rd_valid,
    output cmd, cmd_valid, ddr_address, ddr_wr_data,
    input  ddr_data_valid, ddr_rd_data,
    output rd_data, rd_underflow
  );
endinterface

// File: rtl/ddr_arbiter.sv
// Three-port DDR command arbiter (camera write, VGA/HDR reads) with read-tag FIFO.
// Optional read starvation guard enabled by defining DDR_ARB_STARVE_GUARD_EN.
module ddr_arbiter #(
  parameter int unsigned ADDR_W       = 25,
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned TAG_DEPTH    = 8,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic         clk_133M,
  input  logic         rst_133M,
  ddr_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_W = $clog2(TAG_DEPTH + 1);
  localparam logic [3:0]  CMD_WR = 4'b0100;
  localparam logic [3:0]  CMD_RD = 4'b0011;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t               state;
  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     outstanding;
  logic                 rr_hdr;

  logic tag_empty, rd_room, vga_elig, hdr_elig, rd_elig, rd_port;
  logic can_grant, force_rd, grant_cam, grant_rd, tag_pop;

`ifdef DDR_ARB_STARVE_GUARD_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] starve_cnt;

  // Consecutive camera wins while a read was eligible; cleared by any other grant.
  always_ff @(posedge clk_133M or posedge rst_133M) begin
    if (rst_133M) begin
      starve_cnt <= '0;
    end else if (grant_cam) begin
      starve_cnt <= rd_elig ? starve_cnt + STARVE_W'(1) : '0;
    end else if (grant_rd) begin
      starve_cnt <= '0;
    end
  end
`endif

  // Eligibility and grant decision, only meaningful while IDLE.
  always_comb begin
    tag_empty = (outstanding == '0);
    rd_room   = (outstanding != CNT_W'(TAG_DEPTH));
    vga_elig  = bus.vga_rd_req && rd_room;
    hdr_elig  = bus.hdr_rd_req && rd_room;
    rd_elig   = vga_elig || hdr_elig;
    rd_port   = (vga_elig && hdr_elig) ? rr_hdr : hdr_elig;
    can_grant = (state == IDLE) && bus.init_done && !bus.cmd_busy;
`ifdef DDR_ARB_STARVE_GUARD_EN
    force_rd  = rd_elig && (starve_cnt >= STARVE_W'(STARVE_LIMIT));
`else
    force_rd  = 1'b0;
`endif
    grant_cam = can_grant && bus.cam_wr_req && !force_rd;
    grant_rd  = can_grant && rd_elig && !grant_cam;
    tag_pop   = bus.ddr_data_valid && !tag_empty;
  end

  assign bus.rd_data      = bus.ddr_rd_data;
  assign bus.vga_rd_valid = tag_pop && !tag_mem[rd_ptr];
  assign bus.hdr_rd_valid = tag_pop &&  tag_mem[rd_ptr];

  // Command FSM: grant in IDLE, cmd_valid pulse leaving ISSUE, HOLD until controller free.
  always_ff @(posedge clk_133M or posedge rst_133M) begin
    if (rst_133M) begin
      state           <= IDLE;
      bus.cmd         <= '0;
      bus.cmd_valid   <= 1'b0;
      bus.ddr_address <= '0;
      bus.ddr_wr_data <= '0;
      bus.cam_wr_ack  <= 1'b0;
      bus.vga_rd_ack  <= 1'b0;
      bus.hdr_rd_ack  <= 1'b0;
      rr_hdr          <= 1'b0;
    end else begin
      bus.cam_wr_ack <= 1'b0;
      bus.vga_rd_ack <= 1'b0;
      bus.hdr_rd_ack <= 1'b0;
      bus.cmd_valid  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_cam) begin
            bus.cam_wr_ack  <= 1'b1;
            bus.cmd         <= CMD_WR;
            bus.ddr_address <= bus.cam_wr_addr;
            bus.ddr_wr_data <= bus.cam_wr_data;
            state           <= ISSUE;
          end else if (grant_rd) begin
            bus.vga_rd_ack  <= !rd_port;
            bus.hdr_rd_ack  <= rd_port;
            bus.cmd         <= CMD_RD;
            bus.ddr_address <= rd_port ? bus.hdr_rd_addr : bus.vga_rd_addr;
            bus.ddr_wr_data <= '0;
            rr_hdr          <= !rr_hdr;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          bus.cmd_valid <= 1'b1;
          state         <= HOLD;
        end
        HOLD: begin
          if (!bus.cmd_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read tag FIFO: push port id on read grant, pop on each returning data beat.
  always_ff @(posedge clk_133M or posedge rst_133M) begin
    if (rst_133M) begin
      tag_mem          <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      outstanding      <= '0;
      bus.rd_underflow <= 1'b0;
    end else begin
      if (grant_rd) begin
        tag_mem[wr_ptr] <= rd_port;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (tag_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (bus.ddr_data_valid && tag_empty) bus.rd_underflow <= 1'b1;
      unique case ({grant_rd, tag_pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_arbiter.sv
// Self-checking bench for ddr_arbiter: directed scenarios then random traffic,
// all checked against a transaction-level reference model.
module tb_ddr_arbiter;
  localparam int unsigned ADDR_W       = 25;
  localparam int unsigned DATA_W       = 128;
  localparam int unsigned TAG_DEPTH    = 8;
  localparam int unsigned STARVE_LIMIT = 8;

  logic clk_133M = 1'b0;
  logic rst_133M;
  always #5 clk_133M = ~clk_133M;

  ddr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ddr_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk_133M(clk_133M),
    .rst_133M(rst_133M),
    .bus(bus)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  int                m_phase;
  int                m_starve;
  bit                m_rr;
  bit                m_uf;
  bit                m_q[$];
  logic [2:0]        m_ack;
  logic              m_cv;
  logic [3:0]        m_cmd;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wd;

  // Observations from the last tick; grant log codes: 0 cam, 1 vga, 2 hdr
  logic [2:0] obs_ack;
  logic [1:0] obs_vv;
  logic       obs_cv;
  int         obs_log[$];

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_phase = 0; m_starve = 0; m_rr = 1'b0; m_uf = 1'b0; m_q.delete();
    m_ack = 3'b000; m_cv = 1'b0; m_cmd = 4'h0; m_addr = '0; m_wd = '0;
  endtask

  // One clock edge of the arbitration rules applied to the inputs present at the edge.
  task automatic model_edge();
    bit vga_e, hdr_e, port, gcam, grd;
    m_ack = 3'b000; m_cv = 1'b0; gcam = 1'b0; grd = 1'b0;
    vga_e = bus.vga_rd_req && (m_q.size() < int'(TAG_DEPTH));
    hdr_e = bus.hdr_rd_req && (m_q.size() < int'(TAG_DEPTH));
    port  = (vga_e && hdr_e) ? m_rr : hdr_e;
    if (m_phase == 1) begin
      m_cv = 1'b1; m_phase = 2;
    end else if (m_phase == 2) begin
      if (!bus.cmd_busy) m_phase = 0;
    end else if (bus.init_done && !bus.cmd_busy) begin
      gcam = bus.cam_wr_req;
`ifdef DDR_ARB_STARVE_GUARD_EN
      if ((vga_e || hdr_e) && m_starve >= int'(STARVE_LIMIT)) gcam = 1'b0;
`endif
      grd = !gcam && (vga_e || hdr_e);
    end
    if (gcam) begin
      m_ack = 3'b001; m_cmd = 4'b0100; m_addr = bus.cam_wr_addr; m_wd = bus.cam_wr_data;
      m_phase = 1;
      m_starve = (vga_e || hdr_e) ? m_starve + 1 : 0;
    end
    if (grd) begin
      m_ack = port ? 3'b100 : 3'b010; m_cmd = 4'b0011;
      m_addr = port ? bus.hdr_rd_addr : bus.vga_rd_addr; m_wd = '0;
      m_rr = !m_rr; m_starve = 0; m_phase = 1;
    end
    if (bus.ddr_data_valid) begin
      if (m_q.size() == 0) m_uf = 1'b1;
      else void'(m_q.pop_front());
    end
    if (grd) m_q.push_back(port);
  endtask

  // One clock cycle: check combinational read routing mid-cycle, then registered outputs after the edge.
  task automatic tick();
    logic [1:0] ev;
    #1;
    ev = 2'b00;
    if (bus.ddr_data_valid && m_q.size() != 0) ev = m_q[0] ? 2'b10 : 2'b01;
    obs_vv = {bus.hdr_rd_valid, bus.vga_rd_valid};
    check("rd_valid{hdr,vga}", DATA_W'(obs_vv), DATA_W'(ev));
    if (bus.ddr_data_valid) check("rd_data", bus.rd_data, bus.ddr_rd_data);
    @(posedge clk_133M);
    model_edge();
    #1;
    obs_ack = {bus.hdr_rd_ack, bus.vga_rd_ack, bus.cam_wr_ack};
    obs_cv  = bus.cmd_valid;
    check("acks{hdr,vga,cam}", DATA_W'(obs_ack), DATA_W'(m_ack));
    check("cmd_valid", DATA_W'(obs_cv), DATA_W'(m_cv));
    check("rd_underflow", DATA_W'(bus.rd_underflow), DATA_W'(m_uf));
    if (m_cv) begin
      check("cmd", DATA_W'(bus.cmd), DATA_W'(m_cmd));
      check("ddr_address", DATA_W'(bus.ddr_address), DATA_W'(m_addr));
      check("ddr_wr_data", bus.ddr_wr_data, m_wd);
    end
    if (obs_ack[0]) obs_log.push_back(0);
    if (obs_ack[1]) obs_log.push_back(1);
    if (obs_ack[2]) obs_log.push_back(2);
  endtask

  task automatic wait_ack(input int port, input int budget, input string tag);
    int n0;
    int got;
    n0 = obs_log.size();
    got = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (obs_log.size() > n0) begin
        got = obs_log[obs_log.size()-1];
        break;
      end
    end
    check(tag, DATA_W'(got), DATA_W'(port));
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * int'(TAG_DEPTH); i++) begin
      if (m_q.size() == 0) break;
      bus.ddr_data_valid = 1'b1;
      bus.ddr_rd_data = DATA_W'({$urandom, $urandom, $urandom, $urandom});
      tick();
    end
    bus.ddr_data_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_133M = 1'b1;
    model_reset();
    @(posedge clk_133M);
    #1;
    rst_133M = 1'b0;
  endtask

  initial begin
    int n0;
    int cnt;
    rst_133M = 1'b1;
    bus.init_done = 1'b0; bus.cmd_busy = 1'b0;
    bus.cam_wr_req = 1'b0; bus.cam_wr_addr = '0; bus.cam_wr_data = '0;
    bus.vga_rd_req = 1'b0; bus.vga_rd_addr = ADDR_W'(32'h0000200);
    bus.hdr_rd_req = 1'b0; bus.hdr_rd_addr = ADDR_W'(32'h0000300);
    bus.ddr_data_valid = 1'b0; bus.ddr_rd_data = '0;
    model_reset();
    repeat (2) @(posedge clk_133M);
    #1;
    check("reset_cmd", DATA_W'(bus.cmd), '0);
    check("reset_cmd_valid", DATA_W'(bus.cmd_valid), '0);
    check("reset_ddr_address", DATA_W'(bus.ddr_address), '0);
    check("reset_ddr_wr_data", bus.ddr_wr_data, '0);
    check("reset_acks", DATA_W'({bus.hdr_rd_ack, bus.vga_rd_ack, bus.cam_wr_ack}), '0);
    check("reset_underflow", DATA_W'(bus.rd_underflow), '0);
    rst_133M = 1'b0;

    // Camera write, first held off by init_done=0
    bus.cam_wr_req = 1'b1;
    bus.cam_wr_addr = ADDR_W'(32'h0000100);
    bus.cam_wr_data = {16{8'hA5}};
    repeat (4) tick();
    check("init_gate_no_grant", DATA_W'(obs_log.size()), '0);
    bus.init_done = 1'b1;
    tick();
    check("cam_ack_pulse", DATA_W'(obs_ack), DATA_W'(3'b001));
    bus.cam_wr_req = 1'b0;
    tick();
    check("cam_cmd_valid", DATA_W'(obs_cv), DATA_W'(1'b1));
    check("cam_cmd", DATA_W'(bus.cmd), DATA_W'(4'b0100));
    check("cam_address", DATA_W'(bus.ddr_address), DATA_W'(32'h0000100));
    check("cam_wr_data", bus.ddr_wr_data, {16{8'hA5}});
    tick();
    check("cam_ack_single", DATA_W'(obs_ack), '0);

    // VGA/HDR round robin and tag routing
    n0 = obs_log.size();
    bus.vga_rd_req = 1'b1; bus.hdr_rd_req = 1'b1;
    repeat (9) tick();
    bus.vga_rd_req = 1'b0; bus.hdr_rd_req = 1'b0;
    check("rr_grant_count", DATA_W'(obs_log.size() - n0), DATA_W'(3));
    check("rr_grant0_vga", DATA_W'(obs_log[n0]), DATA_W'(1));
    check("rr_grant1_hdr", DATA_W'(obs_log[n0+1]), DATA_W'(2));
    check("rr_grant2_vga", DATA_W'(obs_log[n0+2]), DATA_W'(1));
    bus.ddr_data_valid = 1'b1;
    bus.ddr_rd_data = {4{32'hDEADBEEF}};
    tick();
    check("beat1_vga", DATA_W'(obs_vv), DATA_W'(2'b01));
    bus.ddr_rd_data = {4{32'h01234567}};
    tick();
    check("beat2_hdr", DATA_W'(obs_vv), DATA_W'(2'b10));
    bus.ddr_data_valid = 1'b0;
    drain();

    // Tag FIFO full: reads withheld, writes still granted
    n0 = obs_log.size();
    bus.vga_rd_req = 1'b1;
    repeat (3 * TAG_DEPTH + 6) tick();
    check("full_read_grants", DATA_W'(obs_log.size() - n0), DATA_W'(TAG_DEPTH));
    bus.cam_wr_req = 1'b1; bus.cam_wr_addr = ADDR_W'(32'h0000ABC);
    wait_ack(0, 4, "full_cam_granted");
    bus.cam_wr_req = 1'b0;
    n0 = obs_log.size();
    repeat (3) tick();
    check("full_read_withheld", DATA_W'(obs_log.size() - n0), '0);
    bus.ddr_data_valid = 1'b1;
    tick();
    bus.ddr_data_valid = 1'b0;
    wait_ack(1, 6, "slot_freed_read");
    bus.vga_rd_req = 1'b0;
    drain();
    check("no_underflow_yet", DATA_W'(bus.rd_underflow), '0);

    // Camera vs held VGA: starvation guard behaviour
    n0 = obs_log.size();
    bus.cam_wr_req = 1'b1; bus.vga_rd_req = 1'b1;
    repeat (30) tick();
    bus.cam_wr_req = 1'b0; bus.vga_rd_req = 1'b0;
    check("starve_grant_count", DATA_W'(obs_log.size() - n0), DATA_W'(10));
    cnt = 0;
    for (int i = 0; i < 8; i++) if (obs_log[n0+i] == 0) cnt++;
    check("starve_first8_cam", DATA_W'(cnt), DATA_W'(8));
`ifdef DDR_ARB_STARVE_GUARD_EN
    check("starve_ninth_vga", DATA_W'(obs_log[n0+8]), DATA_W'(1));
    check("starve_tenth_cam", DATA_W'(obs_log[n0+9]), DATA_W'(0));
`else
    cnt = 0;
    for (int i = 8; i < 10; i++) if (obs_log[n0+i] == 1) cnt++;
    check("strict_no_vga", DATA_W'(cnt), '0);
`endif
    repeat (3) tick();
    drain();

    // cmd_busy stretches HOLD; then underflow on empty FIFO
    bus.cam_wr_req = 1'b1;
    wait_ack(0, 4, "busy_cam_grant");
    bus.cam_wr_req = 1'b0;
    bus.cmd_busy = 1'b1;
    bus.vga_rd_req = 1'b1;
    cnt = 0;
    n0 = obs_log.size();
    repeat (6) begin tick(); cnt += int'(obs_cv); end
    check("busy_single_cmd_valid", DATA_W'(cnt), DATA_W'(1));
    check("busy_no_grant", DATA_W'(obs_log.size() - n0), '0);
    bus.cmd_busy = 1'b0;
    wait_ack(1, 4, "busy_release_grant");
    bus.vga_rd_req = 1'b0;
    repeat (3) tick();
    drain();
    bus.ddr_data_valid = 1'b1;
    tick();
    bus.ddr_data_valid = 1'b0;
    check("underflow_set", DATA_W'(bus.rd_underflow), DATA_W'(1'b1));
    check("underflow_no_valid", DATA_W'(obs_vv), '0);
    tick();
    check("underflow_sticky", DATA_W'(bus.rd_underflow), DATA_W'(1'b1));

    // Reset during an in-flight read
    bus.vga_rd_req = 1'b1;
    wait_ack(1, 4, "pre_reset_read");
    bus.vga_rd_req = 1'b0;
    tick();
    check("pre_reset_cmd_valid", DATA_W'(obs_cv), DATA_W'(1'b1));
    #2 rst_133M = 1'b1;
    #1;
    check("async_rst_cmd_valid", DATA_W'(bus.cmd_valid), '0);
    check("async_rst_cmd", DATA_W'(bus.cmd), '0);
    check("async_rst_address", DATA_W'(bus.ddr_address), '0);
    check("async_rst_underflow", DATA_W'(bus.rd_underflow), '0);
    model_reset();
    @(posedge clk_133M);
    #1;
    rst_133M = 1'b0;
    bus.ddr_data_valid = 1'b1;
    tick();
    bus.ddr_data_valid = 1'b0;
    check("discarded_read_valid", DATA_W'(obs_vv), '0);
    check("discarded_read_underflow", DATA_W'(bus.rd_underflow), DATA_W'(1'b1));
    bus.cam_wr_req = 1'b1;
    wait_ack(0, 3, "post_reset_grant");
    bus.cam_wr_req = 1'b0;
    repeat (3) tick();
    do_reset();

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (obs_ack[0]) bus.cam_wr_req = 1'b0;
      if (obs_ack[1]) bus.vga_rd_req = 1'b0;
      if (obs_ack[2]) bus.hdr_rd_req = 1'b0;
      if (!bus.cam_wr_req && $urandom_range(0, 3) == 0) begin
        bus.cam_wr_req = 1'b1;
        bus.cam_wr_addr = ADDR_W'($urandom);
        bus.cam_wr_data = DATA_W'({$urandom, $urandom, $urandom, $urandom});
      end
      if (!bus.vga_rd_req && $urandom_range(0, 2) == 0) begin
        bus.vga_rd_req = 1'b1;
        bus.vga_rd_addr = ADDR_W'($urandom);
      end
      if (!bus.hdr_rd_req && $urandom_range(0, 2) == 0) begin
        bus.hdr_rd_req = 1'b1;
        bus.hdr_rd_addr = ADDR_W'($urandom);
      end
      bus.cmd_busy = ($urandom_range(0, 4) == 0);
      bus.init_done = ($urandom_range(0, 40) != 0);
      bus.ddr_data_valid = (m_q.size() != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 60) == 0);
      bus.ddr_rd_data = DATA_W'({$urandom, $urandom, $urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ddr_arbiter.md
DDR_ARBITER -- requirements
Module: ddr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, DDR word address width.
REQ-002 SHALL have parameter DATA_W, default 128, DDR data width.
REQ-003 SHALL have parameter TAG_DEPTH, default 8, max outstanding reads (power of 2).
REQ-004 SHALL have parameter STARVE_LIMIT, default 8, consecutive camera grants before a forced read grant.
REQ-005 SHALL have ports: clk_133M  in  1  sole clock; rst_133M  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: init_done  in  1  DDR calibrated; cmd_busy  in  1  DDR controller cannot accept a command.
REQ-007 SHALL have ports: cam_wr_req  in  1 / cam_wr_addr  in  ADDR_W / cam_wr_data  in  DATA_W / cam_wr_ack  out  1, camera write port.
REQ-008 SHALL have ports: vga_rd_req  in  1 / vga_rd_addr  in  ADDR_W / vga_rd_ack  out  1 / vga_rd_valid  out  1, VGA read port.
REQ-009 SHALL have ports: hdr_rd_req  in  1 / hdr_rd_addr  in  ADDR_W / hdr_rd_ack  out  1 / hdr_rd_valid  out  1, HDR read port.
REQ-010 SHALL have ports: cmd  out  4, cmd_valid  out  1, ddr_address  out  ADDR_W, ddr_wr_data  out  DATA_W, command to DDR controller.
REQ-011 SHALL have ports: ddr_data_valid  in  1, ddr_rd_data  in  DATA_W, rd_data  out  DATA_W, rd_underflow  out  1.

Function
REQ-012 SHALL implement FSM IDLE -> ISSUE -> HOLD -> IDLE; one command per 3 cycles max.
REQ-013 SHALL, in IDLE with init_done=1, cmd_busy=0 and an eligible request, grant one requester, pulse its ack for one cycle, latch address/data, go to ISSUE.
REQ-014 SHALL assert cmd_valid for exactly the ISSUE cycle, with cmd=4'b0100 for writes, 4'b0011 for reads; ddr_wr_data=0 for reads.
REQ-015 SHALL, in HOLD, wait one cycle, then return to IDLE only when cmd_busy=0; otherwise stay in HOLD.
REQ-016 SHALL prioritise camera over reads; between vga and hdr, SHALL round-robin, pointer toggling only on a read grant.
REQ-017 SHALL treat a read request as ineligible when TAG_DEPTH reads are outstanding; writes remain eligible.
REQ-018 SHALL push a 1-bit port tag (0=vga, 1=hdr) into the tag FIFO on each read grant.
REQ-019 SHALL, per ddr_data_valid beat, pop one tag and assert the matching vga_rd_valid or hdr_rd_valid in the same cycle; rd_data = ddr_rd_data combinationally.
REQ-020 SHALL support simultaneous push and pop with outstanding count unchanged.
REQ-021 SHALL, on ddr_data_valid with tag FIFO empty, assert no valid and set sticky rd_underflow until reset.
REQ-022 SHALL ignore requests while init_done=0; requesters hold req until ack.
REQ-023 SHALL sample requests only in IDLE; req changes in ISSUE/HOLD have no effect.

Reset
REQ-024 SHALL, on rst_133M=1 at any time, immediately force IDLE, cmd=0, cmd_valid=0, ddr_address=0, ddr_wr_data=0, all acks/valids=0, rd_underflow=0, tag FIFO empty, RR pointer to vga, starve counter 0.
REQ-025 SHALL discard in-flight reads on reset mid-operation; later data beats set rd_underflow.

Configuration
REQ-026 SHALL honour macro DDR_ARB_STARVE_GUARD_EN.
REQ-027 SHALL, when defined, count consecutive camera grants with an eligible read pending; at STARVE_LIMIT the next grant goes to the RR read winner and the count clears.
REQ-028 SHALL, when undefined, apply strict camera priority with no counter logic.

Verification
REQ-029 SHALL cover: cam_wr_req with addr 0x0000100, data 0xA5..A5 -> cam_wr_ack one cycle, cmd_valid next cycle with cmd=4'b0100, ddr_address=0x0000100.
REQ-030 SHALL cover: vga_rd_req and hdr_rd_req held -> grants alternate vga, hdr, vga; two data beats route vga_rd_valid then hdr_rd_valid.
REQ-031 SHALL cover: 8 read grants with no return data -> ninth read withheld, camera write still granted; one beat frees a slot.
REQ-032 SHALL cover: cam and vga held with guard enabled, STARVE_LIMIT=8 -> 8 camera grants then 1 vga grant; with guard disabled, vga never granted.
REQ-033 SHALL cover: cmd_busy=1 in HOLD for 5 cycles -> no new cmd_valid until cmd_busy drops; ddr_data_valid with 0 outstanding -> rd_underflow=1.
REQ-034 SHALL cover: rst_133M asserted mid-ISSUE -> cmd_valid=0 same cycle, FSM IDLE, outstanding count 0.
